// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER backing-memory arbiter.
package otter_mem_pkg;

    typedef enum logic [1:0] {IDLE, BURST_I, BURST_D, DONE} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/line_burst_counter.sv
// Word counter for one cache-line burst: clear on grant, step on each memory ack.
module line_burst_counter #(
    parameter  int LINE_WORDS = 8,
    localparam int CW         = $clog2(LINE_WORDS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          last
);

    // Natural wrap returns cnt to 0 on the final ack of a line.
    always_ff @(posedge CLK) begin
        if (RST || clr) cnt <= '0;
        else if (inc)   cnt <= cnt + 1'b1;
    end

    assign last = (cnt == CW'(LINE_WORDS - 1));

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares the single backing-memory port between I-cache refills and
// D-cache refills/writebacks as fixed-length line bursts.
module otter_mem_arbiter
    import otter_mem_pkg::*;
#(
    parameter  int LINE_WORDS = 8,
    parameter  int ADDR_W     = 32,
    localparam int CW         = $clog2(LINE_WORDS)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [31:0]       ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic [CW-1:0]     dc_widx,
    output logic [31:0]       dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int                WB_SH     = $clog2(WORD_BYTES);
    localparam int                OFS       = CW + WB_SH;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFS) - 64'd1);

    arb_state_t        state, state_nx;
    owner_t            owner, last_grant;
    logic [ADDR_W-1:0] base;
    logic              we_l;
    logic              grant_i, grant_d;
    logic              in_burst, wr_beat, final_ack;
    logic [CW-1:0]     cnt;
    logic              cnt_last;

    assign in_burst  = (state == BURST_I) || (state == BURST_D);
    assign final_ack = in_burst && mem_ack && cnt_last;

    line_burst_counter #(.LINE_WORDS(LINE_WORDS)) u_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (grant_i || grant_d),
        .inc  (in_burst && mem_ack),
        .cnt  (cnt),
        .last (cnt_last)
    );

    always_comb begin
        state_nx = state;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state)
            IDLE: begin
                // On a tie, whoever was not served last goes first.
                if (dc_req && (!ic_req || last_grant == OWN_I)) begin
                    grant_d  = 1'b1;
                    state_nx = BURST_D;
                end else if (ic_req) begin
                    grant_i  = 1'b1;
                    state_nx = BURST_I;
                end
            end
            BURST_I, BURST_D: if (mem_ack && cnt_last) state_nx = DONE;
            DONE:             state_nx = IDLE;
            default:          state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            base       <= '0;
            we_l       <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant_d) begin
                base  <= dc_addr & LINE_MASK;
                we_l  <= dc_we;
                owner <= OWN_D;
            end else if (grant_i) begin
                base  <= ic_addr & LINE_MASK;
                we_l  <= 1'b0;
                owner <= OWN_I;
            end
            if (final_ack) last_grant <= owner;
        end
    end

    assign wr_beat   = (state == BURST_D) && we_l;
    assign busy      = (state != IDLE);
    assign mem_req   = in_burst;
    assign mem_we    = in_burst && we_l;
    assign mem_addr  = in_burst ? (base | (ADDR_W'(cnt) << WB_SH)) : '0;
    assign dc_widx   = wr_beat ? cnt : '0;
    assign mem_wdata = wr_beat ? dc_wdata : '0;

    // Read data is a straight pass-through of the memory word on its ack.
    assign ic_rvalid = (state == BURST_I) && !we_l && mem_ack;
    assign dc_rvalid = (state == BURST_D) && !we_l && mem_ack;
    assign ic_rdata  = ic_rvalid ? mem_rdata : '0;
    assign dc_rdata  = dc_rvalid ? mem_rdata : '0;

    assign ic_done   = (state == DONE) && (owner == OWN_I);
    assign dc_done   = (state == DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: expected beats/done pulses are
// queued as requests are raised and retired when the memory port acks.
module tb_otter_mem_arbiter;

    localparam int LW = 8;
    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ic_req, dc_req, dc_we;
    logic [31:0]   ic_addr, dc_addr, dc_wdata;
    logic [31:0]   ic_rdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;
    logic          ic_rvalid, ic_done, dc_rvalid, dc_done;
    logic [CW-1:0] dc_widx;
    logic          mem_req, mem_we, mem_ack, busy;

    otter_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_widx(dc_widx), .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid),
        .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    // D-cache line contents as seen through the word index.
    assign dc_wdata = 32'h5500 + 32'(dc_widx);

    typedef struct {
        logic        own_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] idx;
    } beat_t;

    beat_t exp_q[$];
    logic  done_q[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    mbeat = 0;
    int    ack_mode = 0;   // 0 off, 1 every cycle, 2 alternate cycles

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic push_burst(input logic own_d, input logic [31:0] base, input logic we);
        for (int i = 0; i < LW; i++) begin
            beat_t b;
            b.own_d = own_d;
            b.addr  = base + 32'(4 * i);
            b.we    = we;
            b.idx   = 32'(i);
            exp_q.push_back(b);
        end
        done_q.push_back(own_d);
    endtask

    task automatic wait_done(input logic own_d);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge CLK); #2;
            if (own_d ? dc_done : ic_done) seen = 1'b1;
        end
        if (!seen) chk(own_d ? "dc_done_timeout" : "ic_done_timeout", 64'd0, 64'd1);
        if (own_d) dc_req = 1'b0;
        else       ic_req = 1'b0;
    endtask

    task automatic wait_beat(input int n);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge CLK); #2;
            if (mbeat == n) seen = 1'b1;
        end
        if (!seen) chk("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_check(input string tag);
        repeat (3) @(posedge CLK);
        #2;
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_q"}, 64'(exp_q.size() + done_q.size()), 64'd0);
    endtask

    // Memory model and monitor: drive ack/rdata, then retire expected beats.
    always @(negedge CLK) begin
        case (ack_mode)
            0:       mem_ack = 1'b0;
            1:       mem_ack = 1'b1;
            default: mem_ack = !mem_ack;
        endcase
        mem_rdata = 32'hA0 + 32'(mbeat);
        #1;
        if (RST === 1'b0) begin
            if (mem_req && mem_ack) begin
                if (exp_q.size() == 0) chk("unexp_beat", 64'd1, 64'd0);
                else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("addr", 64'(mem_addr), 64'(e.addr));
                    chk("we", 64'(mem_we), 64'(e.we));
                    chk("wdata", 64'(mem_wdata), e.we ? 64'(32'h5500 + e.idx) : 64'd0);
                    chk("rvalid", {62'd0, ic_rvalid, dc_rvalid},
                        e.we ? 64'd0 : (e.own_d ? 64'd1 : 64'd2));
                    if (!e.we)
                        chk("rdata", 64'(e.own_d ? dc_rdata : ic_rdata), 64'(32'hA0 + e.idx));
                end
                mbeat = (mbeat + 1) % LW;
            end else if (mem_req) begin
                if (exp_q.size() > 0) chk("hold_addr", 64'(mem_addr), 64'(exp_q[0].addr));
                chk("stall_rvalid", {62'd0, ic_rvalid, dc_rvalid}, 64'd0);
            end else if (mem_ack) begin
                chk("spur_rvalid", {62'd0, ic_rvalid, dc_rvalid}, 64'd0);
            end
            if (ic_done || dc_done) begin
                if (done_q.size() == 0) chk("unexp_done", 64'd1, 64'd0);
                else begin
                    logic d;
                    d = done_q.pop_front();
                    chk("done_owner", {62'd0, ic_done, dc_done}, d ? 64'd1 : 64'd2);
                end
            end
        end
    end

    initial begin
        RST = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", {60'd0, ic_rvalid, dc_rvalid, ic_done, dc_done}, 64'd0);
        chk("rst_widx", 64'(dc_widx), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        RST = 1'b0;

        // I-only read, unaligned miss address
        push_burst(1'b0, 32'h1220, 1'b0);
        ack_mode = 1; ic_addr = 32'h1234; ic_req = 1'b1;
        @(posedge CLK); #2;
        chk("grant_lat", 64'(mem_req), 64'd1);
        wait_done(1'b0);
        idle_check("i_only");

        // D writeback with alternate-cycle acks; addr/we changes after grant ignored
        push_burst(1'b1, 32'h2000, 1'b1);
        ack_mode = 2; dc_we = 1'b1; dc_addr = 32'h2000; dc_req = 1'b1;
        wait_beat(2);
        dc_we = 1'b0; dc_addr = 32'hFFFF_0000;
        wait_done(1'b1);
        idle_check("d_wb");

        // Ties after reset: D, then I, then D again
        RST = 1'b1; @(posedge CLK); #2; RST = 1'b0;
        ack_mode = 1;
        push_burst(1'b1, 32'h3000, 1'b0);
        push_burst(1'b0, 32'h4000, 1'b0);
        dc_addr = 32'h3004; ic_addr = 32'h4010; dc_req = 1'b1; ic_req = 1'b1;
        wait_done(1'b1);
        wait_done(1'b0);
        repeat (2) @(posedge CLK);
        #2;
        push_burst(1'b1, 32'h3000, 1'b0);
        push_burst(1'b0, 32'h4000, 1'b0);
        dc_req = 1'b1; ic_req = 1'b1;
        wait_done(1'b1);
        wait_done(1'b0);
        idle_check("tie");

        // I request dropped after the 3rd ack
        push_burst(1'b0, 32'h5000, 1'b0);
        ic_addr = 32'h5000; ic_req = 1'b1;
        wait_beat(3);
        ic_req = 1'b0;
        wait_done(1'b0);
        idle_check("drop");

        // Reset after the 4th ack of a D read abandons the burst
        push_burst(1'b1, 32'h6000, 1'b0);
        dc_we = 1'b0; dc_addr = 32'h6018; dc_req = 1'b1;
        wait_beat(4);
        @(posedge CLK); #2;
        RST = 1'b1; ack_mode = 0; dc_req = 1'b0;
        @(posedge CLK); #2;
        chk("rstmid_req", 64'(mem_req), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", {62'd0, ic_done, dc_done}, 64'd0);
        exp_q.delete(); done_q.delete(); mbeat = 0;
        RST = 1'b0;

        // Spurious acks while idle change nothing
        ack_mode = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge CLK); #2;
            chk("spur_busy", {62'd0, busy, mem_req}, 64'd0);
        end

        // Fresh D request restarts from word 0 of the line
        push_burst(1'b1, 32'h6000, 1'b0);
        dc_req = 1'b1;
        wait_done(1'b1);
        idle_check("fresh");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
